// File: rtl/lambdagen_ctrl.sv
// Issue/flow controller for the three-stage lambda-generation pipeline: admission, raster FIFO credits,
// culling and end-of-frame drain. Define LAMBDAGEN_CTRL_STATS_EN to build the per-frame statistics counters.
module lambdagen_ctrl #(
  parameter int IDWIDTH = 16,
  parameter int CREDITS = 8,
  parameter int CWIDTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [IDWIDTH-1:0]  in_tID,
  output logic                in_ready,
  output logic                pipe_valid,
  output logic                pipe_stall,
  output logic [IDWIDTH-1:0]  pipe_tID,
  input  logic                s3_ovalid,
  input  logic signed [31:0]  s3_area,
  input  logic [IDWIDTH-1:0]  s3_tID,
  output logic                out_push,
  output logic [IDWIDTH-1:0]  out_tID,
  input  logic                credit_return,
  input  logic                frame_end,
  output logic                frame_done,
  output logic                busy,
  output logic                err_credit,
  output logic [15:0]         stat_issued,
  output logic [15:0]         stat_culled
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CWIDTH-1:0] CREDITS_C = CWIDTH'(CREDITS);

  state_t              state_r;
  state_t              state_next_s;
  logic [CWIDTH-1:0]   credits_r;
  logic [CWIDTH-1:0]   credits_next_s;
  logic [CWIDTH-1:0]   inflight_r;
  logic [CWIDTH-1:0]   inflight_next_s;
  logic [CWIDTH:0]     credit_sum_s;
  logic                credit_ovf_s;
  logic                retire_underflow_s;
  logic                err_credit_r;
  logic                out_push_r;
  logic [IDWIDTH-1:0]  out_tid_r;
  logic                frame_done_r;
  logic                in_ready_s;
  logic                issue_s;
  logic                keep_s;
  logic                cull_s;
  logic                drain_empty_s;

  // Classify the s3 result: positive area goes to the raster FIFO, anything else is culled.
  always_comb begin
    keep_s = 1'b0;
    cull_s = 1'b0;
    if (s3_ovalid) begin
      if (s3_area > 32'sd0) begin
        keep_s = 1'b1;
      end else begin
        cull_s = 1'b1;
      end
    end else begin
      keep_s = 1'b0;
      cull_s = 1'b0;
    end
  end

  // Issue-side outputs; zero-cycle pass-through from setup into s1.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      ST_RUN:   in_ready_s = (credits_r != {CWIDTH{1'b0}});
      ST_DRAIN: in_ready_s = 1'b0;
      ST_DONE:  in_ready_s = 1'b0;
      default:  in_ready_s = 1'b0;
    endcase
    issue_s = in_valid && in_ready_s;
  end

  assign in_ready   = in_ready_s;
  assign pipe_valid = issue_s;
  assign pipe_stall = !in_ready_s;
  assign pipe_tID   = in_tID;
  assign busy       = (inflight_r != {CWIDTH{1'b0}}) || (state_r != ST_RUN);
  assign out_push   = out_push_r;
  assign out_tID    = out_tid_r;
  assign frame_done = frame_done_r;
  assign err_credit = err_credit_r;

  // Credits sum all same-cycle events into one update, saturating at the FIFO depth.
  always_comb begin
    credit_sum_s = {1'b0, credits_r}
                 + (CWIDTH+1)'(credit_return)
                 + (CWIDTH+1)'(cull_s)
                 - (CWIDTH+1)'(issue_s);
    credit_ovf_s = (credit_sum_s > {1'b0, CREDITS_C});
    if (credit_ovf_s) begin
      credits_next_s = CREDITS_C;
    end else begin
      credits_next_s = credit_sum_s[CWIDTH-1:0];
    end
  end

  // In-flight count; a retire with nothing in flight is an error and never wraps the counter.
  always_comb begin
    retire_underflow_s = s3_ovalid && (inflight_r == {CWIDTH{1'b0}});
    if (s3_ovalid && !retire_underflow_s) begin
      inflight_next_s = inflight_r + CWIDTH'(issue_s) - CWIDTH'(1'b1);
    end else begin
      inflight_next_s = inflight_r + CWIDTH'(issue_s);
    end
  end

  assign drain_empty_s = (inflight_r == {CWIDTH{1'b0}}) && !s3_ovalid && !out_push_r;

  // Frame sequencing: next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (frame_end) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_empty_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_DONE: state_next_s = ST_RUN;
      default: state_next_s = ST_RUN;
    endcase
  end

  // Frame sequencing: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Credit, in-flight and sticky error bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_r    <= CREDITS_C;
      inflight_r   <= {CWIDTH{1'b0}};
      err_credit_r <= 1'b0;
    end else begin
      credits_r    <= credits_next_s;
      inflight_r   <= inflight_next_s;
      err_credit_r <= err_credit_r || credit_ovf_s || retire_underflow_s;
    end
  end

  // Registered raster push and frame_done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_push_r   <= 1'b0;
      out_tid_r    <= {IDWIDTH{1'b0}};
      frame_done_r <= 1'b0;
    end else begin
      out_push_r   <= keep_s;
      out_tid_r    <= keep_s ? s3_tID : out_tid_r;
      frame_done_r <= (state_next_s == ST_DONE);
    end
  end

`ifdef LAMBDAGEN_CTRL_STATS_EN
  logic [15:0] stat_issued_r;
  logic [15:0] stat_culled_r;

  function automatic logic [15:0] sat_inc(input logic [15:0] val, input logic inc);
    if (inc && (val != 16'hFFFF)) begin
      return val + 16'd1;
    end else begin
      return val;
    end
  endfunction

  // Per-frame statistics; cleared on the cycle after frame_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued_r <= 16'd0;
      stat_culled_r <= 16'd0;
    end else if (state_r == ST_DONE) begin
      stat_issued_r <= 16'd0;
      stat_culled_r <= 16'd0;
    end else begin
      stat_issued_r <= sat_inc(stat_issued_r, issue_s);
      stat_culled_r <= sat_inc(stat_culled_r, cull_s);
    end
  end

  assign stat_issued = stat_issued_r;
  assign stat_culled = stat_culled_r;
`else
  assign stat_issued = 16'd0;
  assign stat_culled = 16'd0;
`endif

endmodule

// File: tb/tb_lambdagen_ctrl.sv
// Directed bench for lambdagen_ctrl with a 3-cycle s1..s3 model and an out_push scoreboard.
`define CHK(TAG, OBS, EXP) \
  begin \
    total++; \
    assert ((OBS) === (EXP)) else begin \
      bad++; \
      $error("FAIL %s observed=%0h expected=%0h", TAG, OBS, EXP); \
    end \
  end

module tb_lambdagen_ctrl;
  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic [15:0]        in_tID;
  logic               in_ready;
  logic               pipe_valid;
  logic               pipe_stall;
  logic [15:0]        pipe_tID;
  logic               s3_ovalid;
  logic signed [31:0] s3_area;
  logic [15:0]        s3_tID;
  logic               out_push;
  logic [15:0]        out_tID;
  logic               credit_return;
  logic               frame_end;
  logic               frame_done;
  logic               busy;
  logic               err_credit;
  logic [15:0]        stat_issued;
  logic [15:0]        stat_culled;

  int total = 0;
  int bad = 0;
  int pushes = 0;

  logic signed [31:0] area_tab [256];
  logic [2:0]         pv;
  logic [15:0]        pt [3];
  logic [15:0]        exp_q [$];

  lambdagen_ctrl #(.IDWIDTH(16), .CREDITS(8), .CWIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_tID(in_tID), .in_ready(in_ready),
    .pipe_valid(pipe_valid), .pipe_stall(pipe_stall), .pipe_tID(pipe_tID),
    .s3_ovalid(s3_ovalid), .s3_area(s3_area), .s3_tID(s3_tID),
    .out_push(out_push), .out_tID(out_tID), .credit_return(credit_return),
    .frame_end(frame_end), .frame_done(frame_done), .busy(busy), .err_credit(err_credit),
    .stat_issued(stat_issued), .stat_culled(stat_culled)
  );

  always #5 clk = ~clk;

  // s1..s3 model: fixed 3-cycle latency; expected pushes queued at issue time
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= 3'b000;
      pt[0] <= 16'd0;
      pt[1] <= 16'd0;
      pt[2] <= 16'd0;
    end else begin
      pv <= {pv[1:0], pipe_valid};
      pt[0] <= pipe_tID;
      pt[1] <= pt[0];
      pt[2] <= pt[1];
      if (pipe_valid && (area_tab[pipe_tID[7:0]] > 0)) exp_q.push_back(pipe_tID);
    end
  end

  assign s3_ovalid = pv[2];
  assign s3_tID    = pt[2];
  assign s3_area   = area_tab[pt[2][7:0]];

  always @(negedge clk) begin
    if (!rst && out_push) begin
      pushes++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL push_unexpected observed=%0h expected=none", out_tID);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        `CHK("push_tid", out_tID, e)
      end
    end
  end

  task automatic send(input logic [15:0] id);
    in_valid = 1'b1;
    in_tID = id;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    #1;
    while ((busy || out_push || (pv != 3'b000)) && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    assert (n < 50) else begin
      bad++;
      $error("FAIL %s drain_timeout observed=%0d expected<50", tag, n);
    end
  endtask

  task automatic ret_credits(input int n);
    for (int k = 0; k < n; k++) begin
      credit_return = 1'b1;
      @(negedge clk);
    end
    credit_return = 1'b0;
  endtask

  initial begin
    int p0, issued, cnt, dcnt, dcyc, last_ov, leak;
    for (int k = 0; k < 256; k++) area_tab[k] = 32'sd100;
    area_tab[5] = 32'sd0;
    area_tab[6] = -32'sd40;
    area_tab[7] = 32'sd7;
    area_tab[40] = -32'sd1;
    rst = 1'b1; in_valid = 1'b0; in_tID = 16'd0; credit_return = 1'b0; frame_end = 1'b0;
    #3;
    `CHK("rst_out_push", out_push, 1'b0)
    `CHK("rst_frame_done", frame_done, 1'b0)
    `CHK("rst_err", err_credit, 1'b0)
    `CHK("rst_credits", dut.credits_r, 4'd8)
    `CHK("rst_busy", busy, 1'b0)
    `CHK("rst_stat_issued", stat_issued, 16'd0)
    @(negedge clk);
    rst = 1'b0;
    #1;
    `CHK("rst_in_ready", in_ready, 1'b1)
    @(negedge clk);

    // 1: basic flow
    p0 = pushes;
    send(16'd1); send(16'd2); send(16'd3);
    drain("t1");
    `CHK("t1_pushes", pushes - p0, 3)
    `CHK("t1_credits", dut.credits_r, 4'd5)
    `CHK("t1_inflight", dut.inflight_r, 4'd0)
    @(negedge clk);
    ret_credits(3);
    `CHK("t1_credits_back", dut.credits_r, 4'd8)

    // 2: backpressure
    issued = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_tID = 16'(10 + i);
      #1;
      if (i == 8) begin
        `CHK("t2_ready_c9", in_ready, 1'b0)
        `CHK("t2_stall_c9", pipe_stall, 1'b1)
      end
      if (pipe_valid) begin
        `CHK("t2_pipe_tid", pipe_tID, in_tID)
        issued++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    `CHK("t2_issued", issued, 8)
    drain("t2a");
    `CHK("t2_credits0", dut.credits_r, 4'd0)
    `CHK("t2_ready0", in_ready, 1'b0)
    @(negedge clk);
    cnt = 0;
    in_valid = 1'b1;
    in_tID = 16'd20;
    credit_return = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (pipe_valid) cnt++;
      @(negedge clk);
      credit_return = 1'b0;
    end
    in_valid = 1'b0;
    `CHK("t2_one_more", cnt, 1)
    drain("t2b");
    @(negedge clk);
    ret_credits(8);
    `CHK("t2_credits8", dut.credits_r, 4'd8)
    `CHK("t2_err", err_credit, 1'b0)

    // 3: culling
    p0 = pushes;
    send(16'd5); send(16'd6); send(16'd7);
    drain("t3");
    `CHK("t3_pushes", pushes - p0, 1)
    `CHK("t3_credits", dut.credits_r, 4'd7)
`ifdef LAMBDAGEN_CTRL_STATS_EN
    `CHK("t3_stat_culled", stat_culled, 16'd2)
    `CHK("t3_stat_issued", stat_issued, 16'd15)
`else
    `CHK("t3_stat_culled_off", stat_culled, 16'd0)
    `CHK("t3_stat_issued_off", stat_issued, 16'd0)
`endif
    ret_credits(1);

    // 4: frame drain with two in flight; handshake in the frame_end cycle still issues
    in_valid = 1'b1; in_tID = 16'd30;
    @(negedge clk);
    in_tID = 16'd31; frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0; in_tID = 16'd32;
    #1;
    `CHK("t4_ready_drain", in_ready, 1'b0)
    `CHK("t4_stall_drain", pipe_stall, 1'b1)
    `CHK("t4_busy", busy, 1'b1)
    `CHK("t4_inflight", dut.inflight_r, 4'd2)
    dcnt = 0; dcyc = -1; last_ov = -1; leak = 0;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      in_valid = (i < 4);
      frame_end = (i == 2);
      #1;
      if (s3_ovalid) last_ov = i;
      if (pipe_valid) leak++;
      if (frame_done) begin
        dcnt++;
        dcyc = i;
`ifdef LAMBDAGEN_CTRL_STATS_EN
        `CHK("t4_stat_issued_done", stat_issued, 16'd17)
`endif
      end
      @(negedge clk);
    end
    in_valid = 1'b0; frame_end = 1'b0;
    `CHK("t4_done_count", dcnt, 1)
    `CHK("t4_done_after_ov", (dcyc > last_ov) && (last_ov >= 0), 1'b1)
    `CHK("t4_no_issue", leak, 0)
    `CHK("t4_stat_cleared", stat_issued, 16'd0)
    `CHK("t4_credits", dut.credits_r, 4'd6)
    ret_credits(2);

    // frame_end while already drained -> frame_done two cycles later
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    #1;
    `CHK("t4b_done_c1", frame_done, 1'b0)
    @(negedge clk);
    #1;
    `CHK("t4b_done_c2", frame_done, 1'b1)
    @(negedge clk);
    #1;
    `CHK("t4b_done_c3", frame_done, 1'b0)

    // 5: issue + credit_return + cull in one cycle from credits=4
    send(16'd39);
    drain("t5a");
    `CHK("t5_credits7", dut.credits_r, 4'd7)
    @(negedge clk);
    send(16'd40); send(16'd41); send(16'd42);
    in_valid = 1'b1; in_tID = 16'd43; credit_return = 1'b1;
    #1;
    `CHK("t5_cull_present", s3_ovalid && (s3_tID == 16'd40), 1'b1)
    `CHK("t5_credits4", dut.credits_r, 4'd4)
    @(negedge clk);
    in_valid = 1'b0; credit_return = 1'b0;
    `CHK("t5_credits5", dut.credits_r, 4'd5)
    `CHK("t5_inflight3", dut.inflight_r, 4'd3)
    drain("t5b");
    @(negedge clk);
    ret_credits(3);
    `CHK("t5_credits8", dut.credits_r, 4'd8)
    `CHK("t5_err_pre", err_credit, 1'b0)
    ret_credits(1);
    `CHK("t5_credits_sat", dut.credits_r, 4'd8)
    `CHK("t5_err_set", err_credit, 1'b1)

    // 6: asynchronous reset while draining
    in_valid = 1'b1; in_tID = 16'd50;
    @(negedge clk);
    in_tID = 16'd51; frame_end = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; frame_end = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    `CHK("t6_push_before", out_push, 1'b1)
    `CHK("t6_busy_before", busy, 1'b1)
    #1;
    rst = 1'b1;
    #1;
    `CHK("t6_push_rst", out_push, 1'b0)
    `CHK("t6_tid_rst", out_tID, 16'd0)
    `CHK("t6_busy_rst", busy, 1'b0)
    `CHK("t6_err_rst", err_credit, 1'b0)
    `CHK("t6_credits_rst", dut.credits_r, 4'd8)
    `CHK("t6_inflight_rst", dut.inflight_r, 4'd0)
    `CHK("t6_stat_rst", stat_issued, 16'd0)
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    `CHK("t6_ready_after", in_ready, 1'b1)
    `CHK("t6_stall_after", pipe_stall, 1'b0)
    @(negedge clk);

    p0 = pushes;
    send(16'd60);
    drain("t7");
    `CHK("t7_push_after_rst", pushes - p0, 1)
    `CHK("sb_empty", exp_q.size(), 0)

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
